// File: rtl/cache_pkg.sv
// cache_pkg: shared cache-level constants and types.
// Holds the store data width, the default write-buffer depth and the
// drain state encoding used by cache_write_buffer.
package cache_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int WB_DEPTH   = 4;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;

    // True when two byte addresses fall in the same 32-bit word.
    function automatic logic wb_same_word(input logic [31:0] a, input logic [31:0] b);
        return (a[31:2] == b[31:2]);
    endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// wb_fifo_mem: circular storage for the posted-write buffer.
// Head/tail pointers wrap modulo DEPTH; a separate count register tells
// full from empty. Exposes the head entry for draining and a flat view of
// every slot (plus the head pointer) so the owner can search by age.
module wb_fifo_mem
    import cache_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [ADDR_WIDTH-1:0]         push_addr_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [ADDR_WIDTH-1:0]         head_addr_o,
    output logic [DATA_WIDTH-1:0]         head_data_o,
    output logic [PTR_W-1:0]              head_ptr_o,
    output logic [CNT_W-1:0]              count_o,
    output logic                          full_o,
    output logic [DEPTH*ADDR_WIDTH-1:0]   entry_addr_o,
    output logic [DEPTH*DATA_WIDTH-1:0]   entry_data_o
);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    // A push is refused whenever the buffer is full, even if a pop happens the same cycle.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != CNT_W'(0));

    // Next-state for slots, pointers and occupancy.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            addr_d[tail_q] = push_addr_i;
            data_d[tail_q] = push_data_i;
            tail_d         = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_ok) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Flatten the slot array for the lookup logic in the parent.
    always_comb begin
        entry_addr_o = '0;
        entry_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[i];
            entry_data_o[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign head_ptr_o  = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posted-write FIFO between the cache controller and DRAM.
// Stores are accepted on wb_valid && wb_ready and drained in order through a
// three-state FSM (IDLE -> REQ -> DONE) over the mem_req/mem_ack handshake.
// WB_DONE inserts one idle cycle between consecutive DRAM requests.
// Optional feature macro WB_FORWARD_EN: when defined, a combinational lookup
// reports the youngest pending store to the same word as rd_addr; when
// undefined, rd_hit/rd_data are tied low and reads must wait for wb_empty.
module cache_write_buffer
    import cache_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_hit,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    wb_empty,
    output logic [$clog2(DEPTH):0]  wb_count,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]       head_addr;
    logic [DATA_WIDTH-1:0]       head_data;
    logic [PTR_W-1:0]            head_ptr;
    logic [CNT_W-1:0]            count;
    logic                        full;
    logic [DEPTH*ADDR_WIDTH-1:0] entry_addr;
    logic [DEPTH*DATA_WIDTH-1:0] entry_data;
    logic                        pop;

    wb_state_t             state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    wb_fifo_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (wb_valid),
        .push_addr_i  (wb_addr),
        .push_data_i  (wb_data),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .head_ptr_o   (head_ptr),
        .count_o      (count),
        .full_o       (full),
        .entry_addr_o (entry_addr),
        .entry_data_o (entry_data)
    );

    // Drain FSM next-state: the DRAM address/data are latched on entry to
    // WB_REQ so they stay constant for the whole request.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        case (state_q)
            WB_IDLE, WB_DONE: begin
                if (count != CNT_W'(0)) begin
                    state_d     = WB_REQ;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end else begin
                    state_d   = WB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            WB_REQ: begin
                if (mem_ack) begin
                    pop       = 1'b1;
                    state_d   = WB_DONE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d   = WB_REQ;
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d   = WB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Drain FSM state and registered DRAM request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_ready  = !full;
    assign wb_count  = count;
    assign wb_empty  = (count == CNT_W'(0)) && (state_q == WB_IDLE);

`ifdef WB_FORWARD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      idx;

    // Walk valid entries oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (entry_addr[int'(idx)*ADDR_WIDTH + 2 +: ADDR_WIDTH-2] == rd_addr[ADDR_WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end

    assign rd_hit  = fwd_hit;
    assign rd_data = fwd_data;
`else
    assign rd_hit  = 1'b0;
    assign rd_data = '0;
`endif

    // Byte-offset bits and the flat view are not consumed in every build.
    logic unused_lookup_bits;
    assign unused_lookup_bits = ^{rd_addr, entry_addr, entry_data, head_ptr};

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Posted-write FIFO between `cache_controller` and `dummy_DRAM` inside `cache_level_top`. It absorbs write-through stores (SW hits and misses) from the controller so stores no longer stall the pipeline for the DRAM write latency. It drains them in order to DRAM over the existing `mem_req` handshake. It also exposes a lookup port so a read miss never returns stale DRAM data past a pending write.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, `cache_pkg::DATA_WIDTH` (32), store data width

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  async active-high reset
- `wb_valid`  in  1  controller offers a store
- `wb_ready`  out  1  buffer can accept; equals !full
- `wb_addr`  in  ADDR_WIDTH  store byte address
- `wb_data`  in  DATA_WIDTH  store data
- `rd_addr`  in  ADDR_WIDTH  read-miss address to check
- `rd_hit`  out  1  a pending entry matches `rd_addr`
- `rd_data`  out  DATA_WIDTH  data of youngest matching entry
- `wb_empty`  out  1  no pending entries and drain FSM idle
- `wb_count`  out  $clog2(DEPTH)+1  occupancy
- `mem_req`  out  1  DRAM request
- `mem_we`  out  1  DRAM write strobe; always 1 when `mem_req`
- `mem_addr`  out  ADDR_WIDTH  head entry address
- `mem_wdata`  out  DATA_WIDTH  head entry data
- `mem_ack`  in  1  DRAM completed request

## Operation
- Circular FIFO: head/tail pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH; count register disambiguates full/empty.
- Push: rising edge with `wb_valid && wb_ready`; entry written at tail, tail++, count++.
- When full, `wb_ready`=0, even if a pop occurs that cycle. Controller holds `wb_valid`/`wb_addr`/`wb_data` until accepted.
- Drain FSM, enum `wb_state_t`:
  - WB_IDLE: if count≠0, go to WB_REQ.
  - WB_REQ: `mem_req`=1 with head address and data. On `mem_ack`, pop (head++, count--) and go to WB_DONE.
  - WB_DONE: `mem_req`=0 for exactly one cycle. Then go to WB_REQ if count≠0, else WB_IDLE.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `mem_ack` outside WB_REQ is ignored.
- Lookup: combinational. Compares `rd_addr[ADDR_WIDTH-1:2]` against every valid entry's word address. The youngest match (closest to tail) drives `rd_data`. Entries are not coalesced; duplicate addresses coexist in order.
- Reset mid-drain: all entries discarded, no DRAM write completes from the buffer, FSM returns to WB_IDLE.

## Timing
- Reset values: `wb_ready`=1, `rd_hit`=0, `rd_data`=0, `wb_empty`=1, `wb_count`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. These are forced asynchronously on `rst` assertion.
- Push-to-`mem_req` latency: 2 cycles from an empty idle buffer. The push edge is followed by the WB_IDLE→WB_REQ edge.
- `mem_addr`/`mem_wdata` are stable for the whole WB_REQ interval.
- Per-entry drain throughput: DRAM ack latency + 1 (WB_DONE) cycles.
- `rd_hit`/`rd_data` reflect state after the last edge. A store pushed at edge N is visible from N onward. An entry popped at edge N is no longer visible after N.
- `wb_empty` is registered-state derived: count==0 && state==WB_IDLE.

## Configuration
- `WB_FORWARD_EN` defined: lookup logic is compiled in, as described above.
- `WB_FORWARD_EN` undefined: `rd_hit` and `rd_data` are tied to 0. The controller must wait for `wb_empty` before issuing a read-miss fill.

## Structure
- `cache_pkg` gains `wb_state_t` (WB_IDLE, WB_REQ, WB_DONE) and `WB_DEPTH` default constant.
- One sub-module, `wb_fifo_mem`: storage array plus pointers and count, with push/pop ports and a flat entry view for lookup. The drain FSM and lookup live in `cache_write_buffer`.

## Test plan
- Reset: assert `rst` 20ns, release → all outputs at reset values; `wb_ready`=1, `wb_empty`=1.
- Single store: push 0x0000_0010/0xDEAD_DEAD, DRAM acks after 3 cycles → `mem_req` rises 2 cycles after push with that address and data; one pop; `wb_count` returns to 0; `wb_empty`=1 one cycle after WB_DONE.
- Fill and wrap: hold `mem_ack`=0 and push 4 stores 0x00,0x04,0x08,0x0C → `wb_ready`=0, 5th store held; release acks → DRAM sees the stores in order, then the held 5th store lands in slot 0 (wrap).
- Simultaneous push and pop at count=2: `wb_count` stays 2, order preserved.
- Forwarding (`WB_FORWARD_EN`): push 0x10/0x1111_1111 then 0x10/0x2222_2222, `rd_addr`=0x12 → `rd_hit`=1, `rd_data`=0x2222_2222. Without the macro → `rd_hit`=0.
- Reset mid-drain: assert `rst` during WB_REQ with count=3 → `mem_req` drops immediately, `wb_count`=0, no further DRAM writes.
